frame_sample_reader: RTL and testbench
======================================

FRAME_SAMPLE_READER -- requirements
Module: frame_sample_reader

Interface
REQ-001 Parameters SHALL be: FFT_N, default 256, samples per output frame; MEM_LAT, default 2, sample-memory read latency in cycles; FIFO_DEPTH, default 4, output buffer entries; ADDR_W, default 32; DATA_W, default 16.
REQ-002 iclk  input  1  sole clock, all logic on rising edge.
REQ-003 irst  input  1  reset, synchronous, active-high.
REQ-004 i_frame_valid  input  1  frame descriptor valid.
REQ-005 o_frame_ready  output  1  descriptor accepted when high with i_frame_valid.
REQ-006 i_frame_start / i_frame_end  input  ADDR_W each  inclusive first/last sample address.
REQ-007 o_mem_req  output  1  read request; o_mem_addr  output  ADDR_W  read address.
REQ-008 i_mem_rdata  input  DATA_W  read data, valid exactly MEM_LAT edges after the edge sampling o_mem_req high.
REQ-009 o_valid  output  1; i_ready  input  1; o_data  output  DATA_W; o_last  output  1  (sample stream to FFT).
REQ-010 o_err  output  1  one-cycle pulse on rejected descriptor; o_busy  output  1  high outside IDLE.

Function
REQ-011 States SHALL be IDLE, FETCH, DRAIN; o_frame_ready SHALL be high only in IDLE.
REQ-012 On accept with i_frame_end >= i_frame_start, the block SHALL latch start, compute L = end-start+1 (ADDR_W+1 bits), set slot counter to 0, go FETCH.
REQ-013 On accept with i_frame_end < i_frame_start, the block SHALL pulse o_err next cycle, stay IDLE, emit no samples.
REQ-014 In FETCH each cycle with credit available, slot k SHALL issue: if k < min(L,FFT_N), o_mem_req=1, o_mem_addr=start+k; else a pad slot with o_mem_req=0.
REQ-015 Credit SHALL be FIFO occupancy + in-flight slots < FIFO_DEPTH; no slot issued otherwise; FIFO SHALL never overflow.
REQ-016 Every slot SHALL traverse a MEM_LAT-deep tag pipeline (valid, pad, last bits) so pad zeros stay in order behind reads.
REQ-017 At pipeline exit, slot SHALL be written into FIFO as data=i_mem_rdata (read) or 0 (pad), last=1 for slot FFT_N-1.
REQ-018 Frames longer than FFT_N SHALL be truncated to first FFT_N samples; exactly FFT_N samples per accepted frame.
REQ-019 After slot FFT_N-1 issues, state SHALL go DRAIN; DRAIN SHALL go IDLE on the edge completing the o_last handshake.
REQ-020 Output SHALL be show-ahead: o_valid = FIFO non-empty; o_data/o_last from FIFO head; transfer on o_valid && i_ready.
REQ-021 While o_valid && !i_ready, o_data and o_last SHALL hold stable.
REQ-022 With i_ready high, first o_valid SHALL assert MEM_LAT+2 cycles after the accept edge; sustained throughput one sample/cycle.
REQ-023 Simultaneous FIFO write and read SHALL be allowed in any occupancy, including full.
REQ-024 Address arithmetic start+k SHALL wrap modulo 2^ADDR_W.

Reset
REQ-025 irst SHALL, on the next edge, set state IDLE, clear FIFO, tag pipeline, counters; o_mem_req, o_valid, o_last, o_err, o_busy =0; o_data=0; o_mem_addr=0.
REQ-026 o_frame_ready SHALL be 0 while irst high and 1 the first cycle after.
REQ-027 Reset mid-frame SHALL discard all in-flight and buffered samples; read data returning after reset SHALL be ignored.

Structure
REQ-028 Shared package pre_fft_pkg SHALL hold FFT_N, MEM_LAT, FIFO_DEPTH, ADDR_W, DATA_W defaults and the state encoding.
REQ-029 Output buffer SHALL be a sub-module sample_fifo (synchronous, show-ahead, DATA_W+1 wide, FIFO_DEPTH entries).

Verification
REQ-030 start=0x100, end=0x1FF, i_ready=1 -> 256 reads 0x100..0x1FF, samples in order, o_last on 256th, first o_valid 4 cycles after accept.
REQ-031 start=0x10, end=0x19 -> 10 memory samples then 246 zeros, 10 o_mem_req pulses total, o_last on 256th.
REQ-032 start=0x0, end=0x3FF -> reads 0x0..0xFF only, 256 samples, 257th address never requested.
REQ-033 start=0x20, end=0x1F -> o_err one-cycle pulse, no o_mem_req, no o_valid, o_frame_ready stays high.
REQ-034 Random i_ready (50%) during full frame -> no lost/duplicated sample, o_data stable while stalled, FIFO never exceeds 4.
REQ-035 irst asserted at sample 100 of a frame -> next cycle all outputs 0, o_frame_ready=1 after release, next frame starts clean with sample from its start address.

Source files
------------

// File: rtl/pre_fft_pkg.sv
// Shared defaults, FSM encoding and tag layout for the pre-FFT sample reader.
package pre_fft_pkg;

  localparam int unsigned FFT_N_DEF      = 256;
  localparam int unsigned MEM_LAT_DEF    = 2;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Per-slot bookkeeping that rides alongside an outstanding memory read.
  typedef struct packed {
    logic valid;
    logic pad;
    logic last;
  } tag_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO; head word is visible whenever the FIFO is non-empty.
module sample_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    empty   = (count == '0);
    do_rd   = rd_en && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts a write
    do_wr   = wr_en && ((count != CW'(DEPTH)) || do_rd);
    rd_data = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/frame_sample_reader.sv
// Reads one frame of samples from memory, zero-pads or truncates it to FFT_N,
// and streams it out through a credit-limited show-ahead buffer.
module frame_sample_reader
  import pre_fft_pkg::*;
#(
  parameter int unsigned FFT_N      = FFT_N_DEF,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              i_frame_valid,
  output logic              o_frame_ready,
  input  logic [ADDR_W-1:0] i_frame_start,
  input  logic [ADDR_W-1:0] i_frame_end,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_err,
  output logic              o_busy
);

  localparam int unsigned KW = (FFT_N > 1) ? $clog2(FFT_N) : 1;
  localparam int unsigned LW = $clog2(FFT_N + 1);
  // stage 0 captures the request edge, then MEM_LAT more edges until read data is valid
  localparam int unsigned TD = MEM_LAT + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(FIFO_DEPTH + TD + 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [KW-1:0]     slot;
  logic [LW-1:0]     n_reads;
  logic              err;
  tag_t              tag_pipe [TD];
  logic [IW-1:0]     inflight;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic [DATA_W:0]   fifo_wr_data;

  logic              accept;
  logic              order_ok;
  logic [ADDR_W:0]   frame_len;
  logic [LW-1:0]     read_limit;
  logic              pop;
  logic              credit;
  logic              issue;
  logic              is_read;
  logic              slot_last;
  tag_t              exit_tag;

  always_comb begin
    o_frame_ready = (state == ST_IDLE) && !irst;
    accept        = o_frame_ready && i_frame_valid;
    order_ok      = (i_frame_end >= i_frame_start);
    frame_len     = {1'b0, i_frame_end} - {1'b0, i_frame_start} + (ADDR_W+1)'(1);
    read_limit    = (frame_len > (ADDR_W+1)'(FFT_N)) ? LW'(FFT_N) : LW'(frame_len);

    o_valid   = !fifo_empty;
    pop       = o_valid && i_ready;
    // the head leaving this cycle is counted as free so a full-rate stream never stalls
    credit    = (IW'(fifo_count) - IW'(pop) + inflight) < IW'(FIFO_DEPTH);
    issue     = (state == ST_FETCH) && credit;
    is_read   = issue && (LW'(slot) < n_reads);
    slot_last = (slot == KW'(FFT_N - 1));

    o_mem_req  = is_read;
    o_mem_addr = is_read ? addr : '0;
    o_data     = fifo_head[DATA_W-1:0];
    o_last     = fifo_head[DATA_W];
    o_busy     = (state != ST_IDLE);
    o_err      = err;

    exit_tag     = tag_pipe[TD-1];
    fifo_wr_data = {exit_tag.last, exit_tag.pad ? {DATA_W{1'b0}} : i_mem_rdata};
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state   <= ST_IDLE;
      addr    <= '0;
      slot    <= '0;
      n_reads <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (order_ok) begin
              addr    <= i_frame_start;
              n_reads <= read_limit;
              slot    <= '0;
              state   <= ST_FETCH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (issue) begin
            slot <= slot + KW'(1);
            if (is_read) begin
              addr <= addr + ADDR_W'(1);
            end
            if (slot_last) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && o_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int unsigned i = 0; i < TD; i++) begin
        tag_pipe[i] <= '0;
      end
      inflight <= '0;
    end else begin
      tag_pipe[0] <= '{valid: issue, pad: !is_read, last: issue && slot_last};
      for (int unsigned i = 1; i < TD; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
      inflight <= inflight + IW'(issue) - IW'(exit_tag.valid);
    end
  end

  sample_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (iclk),
    .rst     (irst),
    .wr_en   (exit_tag.valid),
    .wr_data (fifo_wr_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_frame_sample_reader.sv
// Directed bench for frame_sample_reader with a fixed-latency memory responder.
module tb_frame_sample_reader;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 16;
  localparam int FFT_N      = 256;
  localparam int MEM_LAT    = 2;
  localparam int FIFO_DEPTH = 4;

  logic              iclk = 1'b0;
  logic              irst = 1'b1;
  logic              i_frame_valid = 1'b0;
  logic              o_frame_ready;
  logic [ADDR_W-1:0] i_frame_start = '0;
  logic [ADDR_W-1:0] i_frame_end = '0;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_valid;
  logic              i_ready = 1'b1;
  logic [DATA_W-1:0] o_data;
  logic              o_last;
  logic              o_err;
  logic              o_busy;

  int total = 0;
  int bad   = 0;

  frame_sample_reader #(
    .FFT_N      (FFT_N),
    .MEM_LAT    (MEM_LAT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) dut (
    .iclk          (iclk),
    .irst          (irst),
    .i_frame_valid (i_frame_valid),
    .o_frame_ready (o_frame_ready),
    .i_frame_start (i_frame_start),
    .i_frame_end   (i_frame_end),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_rdata   (i_mem_rdata),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_last        (o_last),
    .o_err         (o_err),
    .o_busy        (o_busy)
  );

  always #5 iclk = ~iclk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'hC3C3;
  endfunction

  // Request captured at the sampling edge; data presented MEM_LAT edges later.
  logic [ADDR_W:0] mem_pipe [MEM_LAT+1];
  always @(posedge iclk) begin
    mem_pipe[0] <= {o_mem_req, o_mem_addr};
    for (int i = 1; i <= MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign i_mem_rdata = mem_pipe[MEM_LAT][ADDR_W] ? mem_word(mem_pipe[MEM_LAT][ADDR_W-1:0]) : 16'hBEEF;

  logic [DATA_W-1:0] samples [$];
  bit                lasts [$];
  logic [ADDR_W-1:0] req_addrs [$];
  int                first_valid;
  int                last_c;
  bit                timed_out;
  int                stall_bad;
  int                occ_bad;
  logic              ready_at_req;

  // Drives one descriptor and records the resulting request/sample streams.
  task automatic run_frame(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                           input bit rnd, input int abort_at);
    logic [DATA_W-1:0] hold_data;
    logic              hold_last;
    bit                stalled;
    bit                done;
    samples.delete(); lasts.delete(); req_addrs.delete();
    first_valid = -1; last_c = -1; timed_out = 0; stall_bad = 0; occ_bad = 0;
    stalled = 0; done = 0; hold_data = '0; hold_last = 0;
    @(negedge iclk);
    i_frame_start = s; i_frame_end = e; i_frame_valid = 1'b1; i_ready = 1'b1;
    #1 ready_at_req = o_frame_ready;
    @(posedge iclk);
    #1 i_frame_valid = 1'b0;
    for (int c = 1; c <= 3000 && !done; c++) begin
      @(negedge iclk);
      i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (o_mem_req) req_addrs.push_back(o_mem_addr);
      if (stalled && (!o_valid || o_data !== hold_data || o_last !== hold_last)) stall_bad++;
      stalled = o_valid && !i_ready;
      hold_data = o_data;
      hold_last = o_last;
      if (o_valid && first_valid < 0) first_valid = c;
      if (o_valid && i_ready) begin
        samples.push_back(o_data);
        lasts.push_back(o_last);
        if (o_last) begin
          done = 1;
          last_c = c;
        end
      end
      if (req_addrs.size() > samples.size() + FIFO_DEPTH) occ_bad++;
      if (abort_at > 0 && samples.size() == abort_at) done = 1;
    end
    if (!done) timed_out = 1;
    if (abort_at <= 0) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic test_reset();
    irst = 1'b1;
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    total++; if (o_frame_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", o_frame_ready); end
    total++; if (o_mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", o_mem_req); end
    total++; if (o_mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", o_mem_addr); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    total++; if (o_data !== '0 || o_last !== 1'b0) begin bad++; $display("FAIL reset_data: got %h/%b want 0/0", o_data, o_last); end
    total++; if (o_err !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL reset_err_busy: got %b/%b want 0/0", o_err, o_busy); end
    irst = 1'b0;
    #1;
    total++; if (o_frame_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", o_frame_ready); end
  endtask

  task automatic test_full_frame();
    int addr_bad = 0;
    int data_bad = 0;
    int last_cnt = 0;
    run_frame(32'h100, 32'h1FF, 1'b0, 0);
    total++; if (ready_at_req !== 1'b1) begin bad++; $display("FAIL full_ready: got %b want 1", ready_at_req); end
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL full_timeout: got %b want 0", timed_out); end
    total++; if (req_addrs.size() != 256) begin bad++; $display("FAIL full_req_count: got %0d want 256", req_addrs.size()); end
    total++; if (samples.size() != 256) begin bad++; $display("FAIL full_sample_count: got %0d want 256", samples.size()); end
    for (int k = 0; k < req_addrs.size(); k++) if (req_addrs[k] !== 32'h100 + k) addr_bad++;
    for (int k = 0; k < samples.size(); k++) begin
      if (samples[k] !== mem_word(32'h100 + k)) data_bad++;
      if (lasts[k]) last_cnt++;
    end
    total++; if (addr_bad != 0) begin bad++; $display("FAIL full_addr_order: got %0d wrong want 0", addr_bad); end
    total++; if (data_bad != 0) begin bad++; $display("FAIL full_data_order: got %0d wrong want 0", data_bad); end
    total++; if (last_cnt != 1 || lasts.size() != 256 || lasts[255] !== 1'b1) begin
      bad++; $display("FAIL full_last: got %0d lasts want 1 on sample 256", last_cnt); end
    total++; if (first_valid != 5) begin bad++; $display("FAIL full_latency: got %0d edges want 4", first_valid - 1); end
    total++; if (last_c != first_valid + 255) begin bad++; $display("FAIL full_throughput: got last at %0d want %0d", last_c, first_valid + 255); end
    total++; if (o_busy !== 1'b0 || o_frame_ready !== 1'b1) begin
      bad++; $display("FAIL full_idle_after: got busy=%b ready=%b want 0/1", o_busy, o_frame_ready); end
  endtask

  task automatic test_short_frame();
    int data_bad = 0;
    int addr_bad = 0;
    run_frame(32'h10, 32'h19, 1'b0, 0);
    total++; if (req_addrs.size() != 10) begin bad++; $display("FAIL short_req_count: got %0d want 10", req_addrs.size()); end
    for (int k = 0; k < req_addrs.size(); k++) if (req_addrs[k] !== 32'h10 + k) addr_bad++;
    total++; if (addr_bad != 0) begin bad++; $display("FAIL short_addr: got %0d wrong want 0", addr_bad); end
    total++; if (samples.size() != 256) begin bad++; $display("FAIL short_sample_count: got %0d want 256", samples.size()); end
    for (int k = 0; k < samples.size(); k++) begin
      if (k < 10 && samples[k] !== mem_word(32'h10 + k)) data_bad++;
      if (k >= 10 && samples[k] !== 16'h0000) data_bad++;
    end
    total++; if (data_bad != 0) begin bad++; $display("FAIL short_data_pad: got %0d wrong want 0", data_bad); end
    total++; if (lasts.size() != 256 || lasts[255] !== 1'b1 || lasts[254] !== 1'b0) begin
      bad++; $display("FAIL short_last: got size %0d want last on 256th", lasts.size()); end
  endtask

  task automatic test_truncate();
    int addr_bad = 0;
    int extra = 0;
    run_frame(32'h0, 32'h3FF, 1'b0, 0);
    total++; if (req_addrs.size() != 256) begin bad++; $display("FAIL trunc_req_count: got %0d want 256", req_addrs.size()); end
    for (int k = 0; k < req_addrs.size(); k++) if (req_addrs[k] !== k) addr_bad++;
    total++; if (addr_bad != 0) begin bad++; $display("FAIL trunc_addr: got %0d wrong want 0", addr_bad); end
    total++; if (samples.size() != 256 || samples[255] !== mem_word(32'hFF)) begin
      bad++; $display("FAIL trunc_samples: got %0d samples want 256 ending %h", samples.size(), mem_word(32'hFF)); end
    for (int c = 0; c < 10; c++) begin
      @(negedge iclk);
      if (o_mem_req || o_valid) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL trunc_no_more_req: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_bad_desc();
    int activity = 0;
    @(negedge iclk);
    i_frame_start = 32'h20; i_frame_end = 32'h1F; i_frame_valid = 1'b1;
    @(posedge iclk);
    #1 i_frame_valid = 1'b0;
    @(negedge iclk);
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL bad_err_pulse: got %b want 1", o_err); end
    total++; if (o_frame_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL bad_stay_idle: got ready=%b busy=%b want 1/0", o_frame_ready, o_busy); end
    @(negedge iclk);
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL bad_err_width: got %b want 0", o_err); end
    for (int c = 0; c < 10; c++) begin
      @(negedge iclk);
      if (o_mem_req || o_valid || !o_frame_ready) activity++;
    end
    total++; if (activity != 0) begin bad++; $display("FAIL bad_no_activity: got %0d cycles want 0", activity); end
  endtask

  task automatic test_random_ready();
    int data_bad = 0;
    run_frame(32'h100, 32'h1FF, 1'b1, 0);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL rnd_timeout: got %b want 0", timed_out); end
    total++; if (samples.size() != 256) begin bad++; $display("FAIL rnd_sample_count: got %0d want 256", samples.size()); end
    for (int k = 0; k < samples.size(); k++) if (samples[k] !== mem_word(32'h100 + k)) data_bad++;
    total++; if (data_bad != 0) begin bad++; $display("FAIL rnd_data_order: got %0d wrong want 0", data_bad); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL rnd_stall_stable: got %0d changes want 0", stall_bad); end
    total++; if (occ_bad != 0) begin bad++; $display("FAIL rnd_occupancy: got %0d overruns want 0", occ_bad); end
    total++; if (lasts.size() != 256 || lasts[255] !== 1'b1) begin bad++; $display("FAIL rnd_last: got size %0d want last on 256th", lasts.size()); end
    i_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    run_frame(32'h200, 32'h2FF, 1'b0, 100);
    total++; if (samples.size() != 100 || samples[99] !== mem_word(32'h263)) begin
      bad++; $display("FAIL mid_pre_reset: got %0d samples want 100 ending %h", samples.size(), mem_word(32'h263)); end
    irst = 1'b1;
    @(negedge iclk);
    total++; if (o_valid !== 1'b0 || o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_last !== 1'b0 || o_err !== 1'b0) begin
      bad++; $display("FAIL mid_outputs_cleared: got v=%b req=%b busy=%b last=%b err=%b want all 0",
                      o_valid, o_mem_req, o_busy, o_last, o_err); end
    total++; if (o_data !== '0 || o_mem_addr !== '0 || o_frame_ready !== 1'b0) begin
      bad++; $display("FAIL mid_data_cleared: got data=%h addr=%h ready=%b want 0/0/0", o_data, o_mem_addr, o_frame_ready); end
    @(negedge iclk);
    irst = 1'b0;
    #1;
    total++; if (o_frame_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after: got %b want 1", o_frame_ready); end
    run_frame(32'h40, 32'h4F, 1'b0, 0);
    total++; if (req_addrs.size() != 16 || req_addrs[0] !== 32'h40) begin
      bad++; $display("FAIL mid_next_reqs: got %0d reqs want 16 from 40", req_addrs.size()); end
    total++; if (samples.size() != 256 || samples[0] !== mem_word(32'h40) || samples[15] !== mem_word(32'h4F) || samples[16] !== 16'h0) begin
      bad++; $display("FAIL mid_next_samples: got %0d samples first %h want 256 first %h", samples.size(),
                      (samples.size() > 0) ? samples[0] : 16'hXXXX, mem_word(32'h40)); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_truncate();
    test_bad_desc();
    test_random_ready();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
